// File: rtl/hazard_pkg.sv
// Shared pipeline hazard constants: Tuse/Tnew stage encodings and scoreboard defaults.
package hazard_pkg;
    localparam logic [1:0] T_D = 2'd0;
    localparam logic [1:0] T_E = 2'd1;
    localparam logic [1:0] T_M = 2'd2;

    localparam int TAG_W       = 3;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
endpackage

// File: rtl/md_timer.sv
// Mult/div occupancy timer: loads the operation latency on start and counts down to idle.
module md_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sel_div,
    output logic busy
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= sel_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign busy = (md_cnt != '0);
endmodule

// File: rtl/grf_scoreboard.sv
// D-stage GPR hazard scoreboard: per-register in-flight write tracking, forwarding
// readiness countdown, stall generation and the mult/div busy window.
module grf_scoreboard #(
    parameter int TAG_W       = hazard_pkg::TAG_W,
    parameter int MULT_CYCLES = hazard_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = hazard_pkg::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [1:0]       tuse_rs,
    input  logic [1:0]       tuse_rt,
    input  logic             issue_we,
    input  logic [4:0]       issue_rd,
    input  logic [1:0]       issue_tnew,
    input  logic             issue_use_md,
    input  logic             md_start,
    input  logic             md_div,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             stall,
    output logic [TAG_W-1:0] issue_tag,
    output logic             rs_pending,
    output logic             rt_pending,
    output logic             md_busy
);
    // Entry 0 is held at its reset value so $0 reads as never busy.
    logic [31:0]      busy;
    logic [1:0]       cnt [32];
    logic [TAG_W-1:0] tag [32];
    logic [TAG_W-1:0] tag_ctr;

    logic hz_rs, hz_rt, hz_md;
    logic accept, do_write;

    assign rs_pending = busy[issue_rs] && (issue_rs != 5'd0);
    assign rt_pending = busy[issue_rt] && (issue_rt != 5'd0);

    assign hz_rs = use_rs && rs_pending && (cnt[issue_rs] > tuse_rs);
    assign hz_rt = use_rt && rt_pending && (cnt[issue_rt] > tuse_rt);
    assign hz_md = issue_use_md && md_busy;

    assign stall     = issue_valid && (hz_rs || hz_rt || hz_md);
    assign accept    = issue_valid && !stall;
    assign do_write  = accept && issue_we && (issue_rd != 5'd0);
    assign issue_tag = tag_ctr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                busy[i] <= 1'b0;
                cnt[i]  <= 2'd0;
                tag[i]  <= '0;
            end
            tag_ctr <= '0;
        end else begin
            // A new issue to a register overrides both decrement and write-back.
            for (int i = 1; i < 32; i++) begin
                if (do_write && issue_rd == 5'(i)) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= issue_tnew;
                    tag[i]  <= tag_ctr;
                end else begin
                    if (busy[i] && cnt[i] != 2'd0)
                        cnt[i] <= cnt[i] - 2'd1;
                    if (wb_valid && wb_addr == 5'(i) && busy[i] && tag[i] == wb_tag)
                        busy[i] <= 1'b0;
                end
            end
            if (do_write)
                tag_ctr <= tag_ctr + 1'b1;
        end
    end

    md_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (accept && md_start),
        .sel_div(md_div),
        .busy   (md_busy)
    );
endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed hazard scenarios plus randomized
// traffic checked against a timestamp-based reference model.
module tb_grf_scoreboard;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rs, issue_rt, issue_rd, wb_addr;
    logic       use_rs, use_rt, issue_we, issue_use_md, md_start, md_div, wb_valid;
    logic [1:0] tuse_rs, tuse_rt, issue_tnew;
    logic [2:0] wb_tag;
    logic       stall, rs_pending, rt_pending, md_busy;
    logic [2:0] issue_tag;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a register's readiness is derived from when it was issued.
    int  cyc = 0;
    bit  m_busy [32];
    int  m_icyc [32];
    int  m_tnew [32];
    int  m_tag  [32];
    int  m_tagctr = 0;
    int  m_md_end = -100;

    grf_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .use_rs(use_rs), .use_rt(use_rt),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_tnew(issue_tnew), .issue_use_md(issue_use_md), .md_start(md_start),
        .md_div(md_div), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag),
        .stall(stall), .issue_tag(issue_tag), .rs_pending(rs_pending),
        .rt_pending(rt_pending), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt(int r);
        int left;
        if (!m_busy[r]) return 0;
        left = m_tnew[r] - (cyc - m_icyc[r] - 1);
        return (left < 0) ? 0 : left;
    endfunction

    function automatic bit m_md_busy();
        return cyc <= m_md_end;
    endfunction

    function automatic bit m_pend(int r);
        return r != 0 && m_busy[r];
    endfunction

    function automatic bit m_stall();
        bit h_rs, h_rt, h_md;
        h_rs = use_rs && m_pend(int'(issue_rs)) && m_cnt(int'(issue_rs)) > int'(tuse_rs);
        h_rt = use_rt && m_pend(int'(issue_rt)) && m_cnt(int'(issue_rt)) > int'(tuse_rt);
        h_md = issue_use_md && m_md_busy();
        return issue_valid && (h_rs || h_rt || h_md);
    endfunction

    task automatic tick();
        bit acc;
        acc = issue_valid && !m_stall();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 0; m_tag[i] = 0; m_tnew[i] = 0; m_icyc[i] = 0;
            end
            m_tagctr = 0;
            m_md_end = -100;
        end else begin
            if (wb_valid && wb_addr != 0 && m_busy[wb_addr] && m_tag[wb_addr] == int'(wb_tag))
                m_busy[wb_addr] = 0;
            if (acc && issue_we && issue_rd != 0) begin
                m_busy[issue_rd] = 1;
                m_icyc[issue_rd] = cyc;
                m_tnew[issue_rd] = int'(issue_tnew);
                m_tag[issue_rd]  = m_tagctr;
                m_tagctr = (m_tagctr + 1) % 8;
            end
            if (acc && md_start)
                m_md_end = cyc + (md_div ? DIV_CYCLES : MULT_CYCLES);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; use_rs = 0; use_rt = 0;
        tuse_rs = 0; tuse_rt = 0; issue_we = 0; issue_rd = 0; issue_tnew = 0;
        issue_use_md = 0; md_start = 0; md_div = 0; wb_valid = 0; wb_addr = 0; wb_tag = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic issue_write(input logic [4:0] rd, input logic [1:0] tnew);
        clear_inputs();
        issue_valid = 1; issue_we = 1; issue_rd = rd; issue_tnew = tnew;
    endtask

    task automatic test_reset();
        do_reset();
        issue_valid = 1; issue_rs = 5; issue_rt = 6; use_rs = 1; use_rt = 1; issue_use_md = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy got %b exp 0", md_busy); end
        n_checks++; if (rs_pending !== 1'b0 || rt_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending got %b%b exp 00", rs_pending, rt_pending); end
        n_checks++; if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", issue_tag); end
        clear_inputs();
    endtask

    task automatic test_fwd_stall();
        do_reset();
        issue_write(5'd2, T_M);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_issue_stall got %b exp 0", stall); end
        tick();
        clear_inputs();
        issue_valid = 1; issue_rs = 2; issue_rt = 3; use_rs = 1; use_rt = 1;
        tuse_rs = T_E; tuse_rt = T_E; issue_we = 1; issue_rd = 4; issue_tnew = T_E;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL addu_c1_stall got %b exp 1", stall); end
        tick();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL addu_c2_stall got %b exp 0", stall); end
        n_checks++; if (rs_pending !== 1'b1) begin n_fail++; $display("FAIL addu_rs_pending got %b exp 1", rs_pending); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        issue_write(5'd2, T_M);
        tick();
        clear_inputs();
        issue_valid = 1; issue_rs = 2; issue_rt = 0; use_rs = 1; use_rt = 1;
        tuse_rs = T_D; tuse_rt = T_D;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_checks++; if (stall !== (k < 3)) begin
                n_fail++; $display("FAIL beq_stall_c%0d got %b exp %b", k, stall, (k < 3)); end
            n_checks++; if (rs_pending !== 1'b1) begin
                n_fail++; $display("FAIL beq_pending_c%0d got %b exp 1", k, rs_pending); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_waw_tags();
        do_reset();
        issue_write(5'd3, T_M);
        #1;
        n_checks++; if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL waw_tag0 got %0d exp 0", issue_tag); end
        tick();
        issue_write(5'd3, T_E);
        #1;
        n_checks++; if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL waw_tag1 got %0d exp 1", issue_tag); end
        tick();
        clear_inputs();
        wb_valid = 1; wb_addr = 3; wb_tag = 0;
        tick();
        clear_inputs();
        issue_rs = 3;
        #1;
        n_checks++; if (rs_pending !== 1'b1) begin n_fail++; $display("FAIL waw_old_wb got %b exp 1", rs_pending); end
        wb_valid = 1; wb_addr = 3; wb_tag = 1;
        tick();
        wb_valid = 0;
        #1;
        n_checks++; if (rs_pending !== 1'b0) begin n_fail++; $display("FAIL waw_new_wb got %b exp 0", rs_pending); end
        n_checks++; if (issue_tag !== 3'd2) begin n_fail++; $display("FAIL waw_tag_ctr got %0d exp 2", issue_tag); end
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        do_reset();
        issue_write(5'd0, T_M);
        tick();
        clear_inputs();
        issue_valid = 1; issue_rs = 0; use_rs = 1; tuse_rs = T_D;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", stall); end
        n_checks++; if (rs_pending !== 1'b0) begin n_fail++; $display("FAIL r0_pending got %b exp 0", rs_pending); end
        n_checks++; if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL r0_tag got %0d exp 0", issue_tag); end
        tick();
        clear_inputs();
    endtask

    task automatic test_md(input logic div, input int exp_cyc);
        int acc_cyc;
        do_reset();
        issue_valid = 1; issue_use_md = 1; md_start = 1; md_div = div;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL md_start_stall got %b exp 0", stall); end
        tick();
        md_start = 0; md_div = 0;
        acc_cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (!stall) begin acc_cyc = k; break; end
            n_checks++; if (md_busy !== 1'b1) begin
                n_fail++; $display("FAIL md_busy_c%0d got %b exp 1", k, md_busy); end
            tick();
        end
        n_checks++; if (acc_cyc != exp_cyc) begin
            n_fail++; $display("FAIL md_accept_cycle div=%b got %0d exp %0d", div, acc_cyc, exp_cyc); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_idle got %b exp 0", md_busy); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        issue_write(5'd5, T_M); tick();
        issue_write(5'd6, T_E); tick();
        issue_write(5'd7, T_M); issue_use_md = 1; md_start = 1; tick();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        issue_valid = 1; issue_rs = 5; issue_rt = 7; use_rs = 1; use_rt = 1; issue_use_md = 1;
        #1;
        n_checks++; if (rs_pending !== 1'b0 || rt_pending !== 1'b0) begin
            n_fail++; $display("FAIL rst_fl_pending got %b%b exp 00", rs_pending, rt_pending); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_fl_md_busy got %b exp 0", md_busy); end
        n_checks++; if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL rst_fl_tag got %0d exp 0", issue_tag); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_fl_stall got %b exp 0", stall); end
        issue_rs = 6;
        #1;
        n_checks++; if (rs_pending !== 1'b0) begin n_fail++; $display("FAIL rst_fl_r6 got %b exp 0", rs_pending); end
        clear_inputs();
    endtask

    task automatic test_random(input int n);
        bit exp_stall;
        do_reset();
        for (int k = 0; k < n; k++) begin
            clear_inputs();
            reset        = ($urandom_range(0, 59) == 0);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_rs     = 5'($urandom_range(0, 7));
            issue_rt     = 5'($urandom_range(0, 7));
            use_rs       = 1'($urandom);
            use_rt       = 1'($urandom);
            tuse_rs      = 2'($urandom_range(0, 2));
            tuse_rt      = 2'($urandom_range(0, 2));
            issue_we     = ($urandom_range(0, 2) != 0);
            issue_rd     = 5'($urandom_range(0, 7));
            issue_tnew   = 2'($urandom_range(0, 2));
            issue_use_md = ($urandom_range(0, 7) == 0);
            md_start     = issue_use_md && ($urandom_range(0, 1) == 0);
            md_div       = 1'($urandom);
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_addr      = 5'($urandom_range(0, 7));
            wb_tag       = ($urandom_range(0, 3) != 0) ? 3'(m_tag[wb_addr]) : 3'($urandom);
            #1;
            exp_stall = m_stall();
            n_checks++; if (stall !== exp_stall) begin
                n_fail++; $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, stall, exp_stall); end
            n_checks++; if (rs_pending !== m_pend(int'(issue_rs)) || rt_pending !== m_pend(int'(issue_rt))) begin
                n_fail++; $display("FAIL rnd_pending cyc %0d got %b%b exp %b%b", cyc, rs_pending, rt_pending,
                                   m_pend(int'(issue_rs)), m_pend(int'(issue_rt))); end
            n_checks++; if (md_busy !== m_md_busy()) begin
                n_fail++; $display("FAIL rnd_md_busy cyc %0d got %b exp %b", cyc, md_busy, m_md_busy()); end
            n_checks++; if (issue_tag !== 3'(m_tagctr)) begin
                n_fail++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", cyc, issue_tag, m_tagctr); end
            tick();
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        #2;
        test_reset();
        test_fwd_stall();
        test_branch();
        test_waw_tags();
        test_rd_zero();
        test_md(1'b0, MULT_CYCLES + 1);
        test_md(1'b1, DIV_CYCLES + 1);
        test_reset_in_flight();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
